// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the memory-bus responder.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;
  localparam int unsigned WAIT_CNT_W        = 4;

  // Word-index width for a RAM of the given depth (at least one bit).
  function automatic int unsigned word_idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sp_word_ram.sv
// Single-port word RAM: synchronous write, synchronous read, no reset.
module sp_word_ram
  import mem_bus_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = word_idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array write and registered read; read port only updates when enabled.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_bus_responder.sv
// Valid/ready memory responder with programmable wait states over a word RAM.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       DEPTH       = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEFAULT_BASE_ADDR),
  parameter int unsigned       WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned     IDX_W = word_idx_w(DEPTH);
  localparam logic [ADDR_W:0] SPAN  = (ADDR_W + 1)'(4 * DEPTH);

  state_e                  state_q;
  logic [WAIT_CNT_W-1:0]   cnt_q;
  logic                    we_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic                    rsp_valid_q;
  logic                    rsp_err_q;
  logic                    rd_hit_q;

  logic                    accept_d;
  logic                    access_d;
  logic                    acc_we_d;
  logic [ADDR_W-1:0]       acc_addr_d;
  logic [DATA_W-1:0]       acc_wdata_d;
  logic [ADDR_W:0]         off_d;
  logic                    legal_d;
  logic [IDX_W-1:0]        idx_d;
  logic [DATA_W-1:0]       ram_rdata;

  // Handshake, access-edge detection and address decode. With zero wait
  // states the access happens on the accept edge, so the live request is used.
  always_comb begin
    accept_d    = (state_q == IDLE) && req_valid && !rst;
    access_d    = !rst && (((WAIT_STATES == 0) && accept_d) ||
                           ((state_q == WAIT) && (cnt_q == WAIT_CNT_W'(1))));
    acc_we_d    = (state_q == IDLE) ? req_we    : we_q;
    acc_addr_d  = (state_q == IDLE) ? req_addr  : addr_q;
    acc_wdata_d = (state_q == IDLE) ? req_wdata : wdata_q;
    off_d       = {1'b0, acc_addr_d} - {1'b0, BASE_ADDR};
    legal_d     = !off_d[ADDR_W] && (off_d < SPAN) && (acc_addr_d[1:0] == 2'b00);
    idx_d       = off_d[IDX_W+1:2];
  end

  // FSM, wait counter, request latch and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_hit_q    <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (access_d) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= !legal_d;
        rd_hit_q    <= legal_d && !acc_we_d;
      end
      unique case (state_q)
        IDLE: begin
          if (accept_d) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= WAIT_CNT_W'(WAIT_STATES);
            state_q <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - WAIT_CNT_W'(1);
          if (cnt_q == WAIT_CNT_W'(1)) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Word storage; written or read only on a legal access edge.
  sp_word_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (access_d && legal_d && acc_we_d),
    .re_i    (access_d && legal_d && !acc_we_d),
    .addr_i  (idx_d),
    .wdata_i (acc_wdata_d),
    .rdata_o (ram_rdata)
  );

  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rd_hit_q ? ram_rdata : '0;

endmodule
